// File: rtl/multicycle_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : multicycle_ctrl_if
// Brief    : Control bundle between the multicycle controller and its datapath.
// Revision : 1.0
// ============================================================================
interface multicycle_ctrl_if;
    logic [5:0] op;
    logic [5:0] funct;
    logic       zero;

    logic       iord;
    logic       alusrca;
    logic       regdst;
    logic       memtoreg;
    logic [1:0] alusrcb;
    logic [1:0] pcsrc;
    logic [1:0] aluop;
    logic       memwrite;
    logic       irwrite;
    logic       regwrite;
    logic       pcwrite;
    logic       branch;
    logic       pcen;
    logic [2:0] alucontrol;
    logic [3:0] state;

    modport master (
        input  op, funct, zero,
        output iord, alusrca, regdst, memtoreg, alusrcb, pcsrc, aluop,
               memwrite, irwrite, regwrite, pcwrite, branch, pcen,
               alucontrol, state
    );

    modport slave (
        output op, funct, zero,
        input  iord, alusrca, regdst, memtoreg, alusrcb, pcsrc, aluop,
               memwrite, irwrite, regwrite, pcwrite, branch, pcen,
               alucontrol, state
    );
endinterface
`default_nettype wire

// File: rtl/multicycle_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : multicycle_ctrl
// Brief    : Moore-style main controller plus ALU decoder for a multicycle MIPS.
// Revision : 1.0
// ============================================================================
module multicycle_ctrl (
    input  wire logic           clk,
    input  wire logic           reset,
    multicycle_ctrl_if.master   bus
);
    typedef enum logic [3:0] {
        FETCH   = 4'd0,
        DECODE  = 4'd1,
        MEMADR  = 4'd2,
        MEMRD   = 4'd3,
        MEMWB   = 4'd4,
        MEMWR   = 4'd5,
        EXECUTE = 4'd6,
        ALUWB   = 4'd7,
        BRANCH  = 4'd8,
        ADDIEX  = 4'd9,
        ADDIWB  = 4'd10,
        JUMP    = 4'd11
    } state_t;

    typedef struct packed {
        logic       iord;
        logic       alusrca;
        logic       regdst;
        logic       memtoreg;
        logic [1:0] alusrcb;
        logic [1:0] pcsrc;
        logic [1:0] aluop;
        logic       memwrite;
        logic       irwrite;
        logic       regwrite;
        logic       pcwrite;
        logic       branch;
    } ctrl_t;

    localparam logic [5:0] c_OP_LW    = 6'b100011;
    localparam logic [5:0] c_OP_SW    = 6'b101011;
    localparam logic [5:0] c_OP_RTYPE = 6'b000000;
    localparam logic [5:0] c_OP_BEQ   = 6'b000100;
    localparam logic [5:0] c_OP_ADDI  = 6'b001000;
    localparam logic [5:0] c_OP_J     = 6'b000010;

    function automatic state_t next_state(input state_t s, input logic [5:0] op);
        state_t n;
        n = FETCH;
        case (s)
            FETCH:   n = DECODE;
            DECODE: begin
                case (op)
                    c_OP_LW, c_OP_SW: n = MEMADR;
                    c_OP_RTYPE:       n = EXECUTE;
                    c_OP_BEQ:         n = BRANCH;
                    c_OP_ADDI:        n = ADDIEX;
                    c_OP_J:           n = JUMP;
                    default:          n = FETCH;
                endcase
            end
            // Only sw writes memory; any other opcode here takes the harmless read path.
            MEMADR:  n = (op == c_OP_SW) ? MEMWR : MEMRD;
            MEMRD:   n = MEMWB;
            EXECUTE: n = ALUWB;
            ADDIEX:  n = ADDIWB;
            default: n = FETCH;
        endcase
        return n;
    endfunction

    function automatic ctrl_t state_outputs(input state_t s);
        ctrl_t c;
        c = '0;
        case (s)
            FETCH: begin
                c.alusrcb = 2'b01;
                c.irwrite = 1'b1;
                c.pcwrite = 1'b1;
            end
            DECODE:  c.alusrcb = 2'b11;
            MEMADR: begin
                c.alusrca = 1'b1;
                c.alusrcb = 2'b10;
            end
            MEMRD:   c.iord = 1'b1;
            MEMWB: begin
                c.memtoreg = 1'b1;
                c.regwrite = 1'b1;
            end
            MEMWR: begin
                c.iord     = 1'b1;
                c.memwrite = 1'b1;
            end
            EXECUTE: begin
                c.alusrca = 1'b1;
                c.aluop   = 2'b10;
            end
            ALUWB: begin
                c.regdst   = 1'b1;
                c.regwrite = 1'b1;
            end
            BRANCH: begin
                c.alusrca = 1'b1;
                c.aluop   = 2'b01;
                c.pcsrc   = 2'b01;
                c.branch  = 1'b1;
            end
            ADDIEX: begin
                c.alusrca = 1'b1;
                c.alusrcb = 2'b10;
            end
            ADDIWB:  c.regwrite = 1'b1;
            JUMP: begin
                c.pcsrc   = 2'b10;
                c.pcwrite = 1'b1;
            end
            default: c = '0;
        endcase
        return c;
    endfunction

    state_t r_state;
    ctrl_t  r_ctrl;
    state_t w_next;

    assign w_next = next_state(r_state, bus.op);

    // Outputs are registered alongside the state so they match it with no decode delay.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= FETCH;
            r_ctrl  <= state_outputs(FETCH);
        end else begin
            r_state <= w_next;
            r_ctrl  <= state_outputs(w_next);
        end
    end

    assign bus.state    = r_state;
    assign bus.iord     = r_ctrl.iord;
    assign bus.alusrca  = r_ctrl.alusrca;
    assign bus.regdst   = r_ctrl.regdst;
    assign bus.memtoreg = r_ctrl.memtoreg;
    assign bus.alusrcb  = r_ctrl.alusrcb;
    assign bus.pcsrc    = r_ctrl.pcsrc;
    assign bus.aluop    = r_ctrl.aluop;

    // Write enables are gated by reset directly so an in-flight write dies in the reset cycle.
    assign bus.memwrite = r_ctrl.memwrite & ~reset;
    assign bus.irwrite  = r_ctrl.irwrite  & ~reset;
    assign bus.regwrite = r_ctrl.regwrite & ~reset;
    assign bus.pcwrite  = r_ctrl.pcwrite  & ~reset;
    assign bus.branch   = r_ctrl.branch   & ~reset;
    assign bus.pcen     = (r_ctrl.pcwrite | (r_ctrl.branch & bus.zero)) & ~reset;

    always_comb begin
        bus.alucontrol = 3'b010;
        case (r_ctrl.aluop)
            2'b01:   bus.alucontrol = 3'b110;
            2'b10: begin
                case (bus.funct)
                    6'b100000: bus.alucontrol = 3'b010;
                    6'b100010: bus.alucontrol = 3'b110;
                    6'b100100: bus.alucontrol = 3'b000;
                    6'b100101: bus.alucontrol = 3'b001;
                    6'b101010: bus.alucontrol = 3'b111;
                    default:   bus.alucontrol = 3'b010;
                endcase
            end
            default: bus.alucontrol = 3'b010;
        endcase
    end
endmodule
`default_nettype wire

// File: tb/tb_multicycle_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_multicycle_ctrl
// Brief    : Randomized instruction stream checked against a table-driven model.
// Revision : 1.0
// ============================================================================
module tb_multicycle_ctrl;
    logic clk;
    logic reset;
    int   n_vectors;
    int   n_miscompares;

    multicycle_ctrl_if bus();

    multicycle_ctrl dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int iord, alusrca, regdst, memtoreg, alusrcb, pcsrc, aluop;
        int memwrite, irwrite, regwrite, pcwrite, branch;
    } exp_t;

    task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vectors++;
        if (obs !== exp) begin
            n_miscompares++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Per-state output table, written straight from the controller's output list.
    function automatic exp_t spec_outputs(input int s);
        exp_t e;
        e = '{default: 0};
        case (s)
            0:  begin e.alusrcb = 1; e.irwrite = 1; e.pcwrite = 1; end
            1:  e.alusrcb = 3;
            2:  begin e.alusrca = 1; e.alusrcb = 2; end
            3:  e.iord = 1;
            4:  begin e.memtoreg = 1; e.regwrite = 1; end
            5:  begin e.iord = 1; e.memwrite = 1; end
            6:  begin e.alusrca = 1; e.aluop = 2; end
            7:  begin e.regdst = 1; e.regwrite = 1; end
            8:  begin e.alusrca = 1; e.aluop = 1; e.pcsrc = 1; e.branch = 1; end
            9:  begin e.alusrca = 1; e.alusrcb = 2; end
            10: e.regwrite = 1;
            11: begin e.pcsrc = 2; e.pcwrite = 1; end
            default: ;
        endcase
        return e;
    endfunction

    function automatic int spec_alucontrol(input int aluop, input logic [5:0] funct);
        if (aluop == 1) return 6;
        if (aluop != 2) return 2;
        case (funct)
            6'b100010: return 6;
            6'b100100: return 0;
            6'b100101: return 1;
            6'b101010: return 7;
            default:   return 2;
        endcase
    endfunction

    // State walk for one instruction, from FETCH up to (not including) the next FETCH.
    function automatic void spec_sequence(input logic [5:0] op, output int seq[$]);
        seq = '{0, 1};
        case (op)
            6'b100011: seq = '{0, 1, 2, 3, 4};
            6'b101011: seq = '{0, 1, 2, 5};
            6'b000000: seq = '{0, 1, 6, 7};
            6'b001000: seq = '{0, 1, 9, 10};
            6'b000100: seq = '{0, 1, 8};
            6'b000010: seq = '{0, 1, 11};
            default:   ;
        endcase
    endfunction

    task automatic check_outputs(input int s);
        exp_t  e;
        string p;
        int    gate;
        e    = spec_outputs(s);
        p    = $sformatf("s%0d", s);
        gate = reset ? 0 : 1;
        check_value({p, ".state"},    32'(bus.state),    32'(s));
        check_value({p, ".iord"},     32'(bus.iord),     32'(e.iord));
        check_value({p, ".alusrca"},  32'(bus.alusrca),  32'(e.alusrca));
        check_value({p, ".regdst"},   32'(bus.regdst),   32'(e.regdst));
        check_value({p, ".memtoreg"}, 32'(bus.memtoreg), 32'(e.memtoreg));
        check_value({p, ".alusrcb"},  32'(bus.alusrcb),  32'(e.alusrcb));
        check_value({p, ".pcsrc"},    32'(bus.pcsrc),    32'(e.pcsrc));
        check_value({p, ".aluop"},    32'(bus.aluop),    32'(e.aluop));
        check_value({p, ".memwrite"}, 32'(bus.memwrite), 32'(e.memwrite & gate));
        check_value({p, ".irwrite"},  32'(bus.irwrite),  32'(e.irwrite & gate));
        check_value({p, ".regwrite"}, 32'(bus.regwrite), 32'(e.regwrite & gate));
        check_value({p, ".pcwrite"},  32'(bus.pcwrite),  32'(e.pcwrite & gate));
        check_value({p, ".branch"},   32'(bus.branch),   32'(e.branch & gate));
        check_value({p, ".pcen"},     32'(bus.pcen),
                    32'((e.pcwrite | (e.branch & int'(bus.zero))) & gate));
        check_value({p, ".alucontrol"}, 32'(bus.alucontrol),
                    32'(spec_alucontrol(e.aluop, bus.funct)));
        check_value({p, ".range"}, 32'(bus.state <= 4'd11), 32'd1);
    endtask

    // zero_mode: -1 random each cycle, else fixed. rst_step: -1 none, else step index.
    task automatic run_instr(input logic [5:0] op, input logic [5:0] funct,
                             input int zero_mode, input int rst_step);
        int seq[$];
        spec_sequence(op, seq);
        for (int i = 0; i < seq.size(); i++) begin
            @(negedge clk);
            // op is only meaningful in FETCH/DECODE/MEMADR; scramble it everywhere else.
            if (seq[i] <= 2) bus.op = op;
            else             bus.op = 6'($urandom);
            bus.funct = funct;
            bus.zero  = (zero_mode < 0) ? 1'($urandom) : 1'(zero_mode);
            reset     = (i == rst_step);
            #1;
            check_outputs(seq[i]);
            if (i == rst_step) break;
        end
    endtask

    initial begin
        logic [5:0] ops [6];
        logic [5:0] functs [5];
        logic [5:0] op;
        logic [5:0] funct;
        int         rs;
        ops    = '{6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b001000, 6'b000010};
        functs = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
        n_vectors     = 0;
        n_miscompares = 0;
        reset     = 1'b1;
        bus.op    = 6'b0;
        bus.funct = 6'b0;
        bus.zero  = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        check_outputs(0);

        run_instr(6'b100011, 6'b000000, -1, -1);
        run_instr(6'b000000, 6'b101010, -1, -1);
        run_instr(6'b000100, 6'b000000,  1, -1);
        run_instr(6'b000100, 6'b000000,  0, -1);
        run_instr(6'b111111, 6'b000000, -1, -1);
        run_instr(6'b101011, 6'b000000, -1,  3);
        run_instr(6'b000010, 6'b000000, -1, -1);
        run_instr(6'b001000, 6'b000000, -1, -1);
        run_instr(6'b000000, 6'b110011, -1, -1);

        for (int n = 0; n < 60; n++) begin
            op    = ($urandom_range(0, 7) == 0) ? 6'($urandom) : ops[$urandom_range(0, 5)];
            funct = ($urandom_range(0, 5) == 0) ? 6'($urandom) : functs[$urandom_range(0, 4)];
            rs    = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 4)) : -1;
            run_instr(op, funct, -1, rs);
        end

        @(negedge clk);
        bus.op = 6'b111111;
        reset  = 1'b0;
        #1;
        check_outputs(0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
        $finish;
    end
endmodule
`default_nettype wire
